// File: rtl/run_monitor.sv
// run_monitor: tracks a core run from start to halt or timeout, with saturating cycle and event counters
module run_monitor #(
  parameter int WIDTH      = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_EVENTS = 4,
  parameter int TIMEOUT    = 500,
  parameter int DRAIN      = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               halt,
  input  logic [DATA_W-1:0]                  ret_val,
  input  logic [NUM_EVENTS-1:0]              events,
  input  logic [$clog2(NUM_EVENTS+1)-1:0]    rd_sel,
  output logic [WIDTH-1:0]                   rd_data,
  output logic                               running,
  output logic                               done,
  output logic                               timed_out,
  output logic [DATA_W-1:0]                  result
);
  localparam int SW = $clog2(NUM_EVENTS + 1);
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cyc_q, cyc_d;
  logic [WIDTH-1:0]  ev_q [NUM_EVENTS];
  logic [WIDTH-1:0]  ev_d [NUM_EVENTS];
  logic [DW-1:0]     drain_q, drain_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              tout_q, tout_d;
  logic              active;
  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign running   = active;
  assign done      = state_q == S_DONE;
  assign timed_out = tout_q;
  assign result    = result_q;
  // Next-state: start clears a run, RUN counts cycles and resolves halt before timeout, DRAIN counts down
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    ev_d     = ev_q;
    drain_d  = drain_q;
    result_d = result_q;
    tout_d   = tout_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      state_d  = S_RUN;
      cyc_d    = '0;
      ev_d     = '{default: '0};
      result_d = '0;
      tout_d   = 1'b0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++)
        if (active && events[i] && ev_q[i] != '1) ev_d[i] = ev_q[i] + 1'b1;
      if (state_q == S_RUN) begin
        cyc_d = (cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
        if (halt) begin
          result_d = ret_val;
          state_d  = (DRAIN == 0) ? S_DONE : S_DRAIN;
          drain_d  = DW'((DRAIN > 0) ? DRAIN - 1 : 0);
        end else if (TIMEOUT != 0 && 64'(cyc_d) == 64'(TIMEOUT)) begin
          state_d = S_DONE;
          tout_d  = 1'b1;
        end
      end else if (state_q == S_DRAIN) begin
        state_d = (drain_q == '0) ? S_DONE : S_DRAIN;
        drain_d = (drain_q == '0) ? drain_q : drain_q - 1'b1;
      end
    end
  end
  // State and counter registers, cleared asynchronously so a mid-run reset takes effect at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      ev_q     <= '{default: '0};
      drain_q  <= '0;
      result_q <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      ev_q     <= ev_d;
      drain_q  <= drain_d;
      result_q <= result_d;
      tout_q   <= tout_d;
    end
  end
  // Readout mux: 0 is the cycle count, k is event counter k-1, anything beyond reads 0
  always_comb begin
    rd_data = (rd_sel == '0) ? cyc_q : '0;
    for (int i = 0; i < NUM_EVENTS; i++)
      if (rd_sel == SW'(i + 1)) rd_data = ev_q[i];
  end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed checks of run_monitor with default-style and narrow/no-timeout configurations
module tb_run_monitor;
  logic        clk, rst_n;
  logic        a_start, a_halt;
  logic [31:0] a_ret;
  logic [3:0]  a_ev;
  logic [2:0]  a_sel;
  logic [31:0] a_rd, a_res;
  logic        a_run, a_done, a_tout;
  logic        b_start, b_halt;
  logic [31:0] b_ret;
  logic [3:0]  b_ev;
  logic [2:0]  b_sel;
  logic [3:0]  b_rd;
  logic [31:0] b_res;
  logic        b_run, b_done, b_tout;
  int vecs = 0;
  int errs = 0;

  run_monitor #(.WIDTH(32), .DATA_W(32), .NUM_EVENTS(4), .TIMEOUT(500), .DRAIN(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .halt(a_halt), .ret_val(a_ret),
    .events(a_ev), .rd_sel(a_sel), .rd_data(a_rd), .running(a_run), .done(a_done),
    .timed_out(a_tout), .result(a_res));

  run_monitor #(.WIDTH(4), .DATA_W(32), .NUM_EVENTS(4), .TIMEOUT(0), .DRAIN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .halt(b_halt), .ret_val(b_ret),
    .events(b_ev), .rd_sel(b_sel), .rd_data(b_rd), .running(b_run), .done(b_done),
    .timed_out(b_tout), .result(b_res));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_halt = 0; a_ret = 0; a_ev = 0; a_sel = 0;
    b_start = 0; b_halt = 0; b_ret = 0; b_ev = 0; b_sel = 0;
    #12;
    chk("rst_running", a_run, 0);
    chk("rst_done", a_done, 0);
    chk("rst_tout", a_tout, 0);
    chk("rst_result", a_res, 0);
    chk("rst_cyc", a_rd, 0);
    #1 rst_n = 1'b1;
    // halt on 10th RUN edge, two drain cycles
    a_start = 1; step(); a_start = 0;
    chk("t1_running", a_run, 1);
    repeat (9) step();
    a_halt = 1; a_ret = 42; step(); a_halt = 0;
    chk("t1_result", a_res, 42);
    chk("t1_drain_running", a_run, 1);
    chk("t1_drain_notdone", a_done, 0);
    step();
    chk("t1_drain1_notdone", a_done, 0);
    step();
    chk("t1_done", a_done, 1);
    chk("t1_running_low", a_run, 0);
    chk("t1_cyc", a_rd, 10);
    chk("t1_tout", a_tout, 0);
    // timeout at 500, restart from DONE clears counters and result
    a_start = 1; step(); a_start = 0;
    chk("t2_cyc_cleared", a_rd, 0);
    chk("t2_result_cleared", a_res, 0);
    chk("t2_done_low", a_done, 0);
    repeat (499) step();
    chk("t2_cyc499", a_rd, 499);
    chk("t2_notdone499", a_done, 0);
    step();
    chk("t2_done", a_done, 1);
    chk("t2_tout", a_tout, 1);
    chk("t2_cyc", a_rd, 500);
    chk("t2_result", a_res, 0);
    chk("t2_no_drain", a_run, 0);
    repeat (3) step();
    chk("t2_cyc_frozen", a_rd, 500);
    chk("t2_done_held", a_done, 1);
    chk("t2_tout_held", a_tout, 1);
    // halt and timeout on the same edge: halt wins
    a_start = 1; step(); a_start = 0;
    chk("t3_tout_cleared", a_tout, 0);
    repeat (499) step();
    a_halt = 1; a_ret = 7; step(); a_halt = 0;
    chk("t3_tout", a_tout, 0);
    chk("t3_result", a_res, 7);
    chk("t3_cyc", a_rd, 500);
    chk("t3_drain", a_run, 1);
    repeat (2) step();
    chk("t3_done", a_done, 1);
    chk("t3_tout_done", a_tout, 0);
    // events in DONE are not counted
    a_ev = 4'hF; a_sel = 1;
    repeat (2) step();
    chk("t4_done_ev_ignored", a_rd, 0);
    a_ev = 0;
    // event counting over RUN and DRAIN, start in RUN ignored
    a_start = 1; step(); a_start = 0;
    for (int k = 1; k <= 22; k++) begin
      a_ev = {2'b00, (k % 2 == 1), 1'b1};
      a_start = (k == 5);
      a_halt = (k == 20);
      a_ret = 32'h33;
      step();
    end
    a_start = 0; a_halt = 0;
    chk("t4_done", a_done, 1);
    chk("t4_result", a_res, 32'h33);
    a_sel = 0; #1;
    chk("t4_cyc", a_rd, 20);
    a_sel = 1; #1;
    chk("t4_ev0", a_rd, 22);
    a_sel = 2; #1;
    chk("t4_ev1", a_rd, 11);
    a_sel = 3; #1;
    chk("t4_ev2", a_rd, 0);
    a_ev = 4'b1111;
    repeat (2) step();
    a_ev = 0;
    a_sel = 1; #1;
    chk("t4_ev0_frozen", a_rd, 22);
    a_sel = 2; #1;
    chk("t4_ev1_frozen", a_rd, 11);
    a_sel = 5; #1;
    chk("t4_sel_oob", a_rd, 0);
    a_sel = 0;
    // asynchronous reset mid-DRAIN
    @(negedge clk);
    a_start = 1; step(); a_start = 0;
    a_ev = 4'b0001;
    repeat (3) step();
    a_halt = 1; a_ret = 99; step(); a_halt = 0;
    chk("t6_in_drain", a_run, 1);
    chk("t6_result_pre", a_res, 99);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_running", a_run, 0);
    chk("t6_rst_done", a_done, 0);
    chk("t6_rst_tout", a_tout, 0);
    chk("t6_rst_result", a_res, 0);
    chk("t6_rst_cyc", a_rd, 0);
    a_sel = 1; #1;
    chk("t6_rst_ev0", a_rd, 0);
    a_sel = 0;
    #1 rst_n = 1'b1;
    a_halt = 1; a_ret = 5;
    step();
    a_halt = 0; a_ev = 0;
    chk("t6_idle_halt_ignored", a_done, 0);
    chk("t6_idle_running", a_run, 0);
    chk("t6_idle_result", a_res, 0);
    // narrow counter saturates, zero drain gives done on the halt edge
    b_start = 1; step(); b_start = 0;
    repeat (15) step();
    chk("t5_cyc15", b_rd, 15);
    repeat (5) step();
    chk("t5_sat", b_rd, 15);
    chk("t5_no_timeout", b_done, 0);
    b_halt = 1; b_ret = 5; step(); b_halt = 0;
    chk("t5_done_on_halt", b_done, 1);
    chk("t5_result", b_res, 5);
    chk("t5_cyc_final", b_rd, 15);
    chk("t5_tout", b_tout, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable, parametrised run monitor for the pipelined core. It sits beside the core top level and tracks a program run from a start pulse until the core halts or a cycle budget expires.
- It captures the return value at halt and waits a configurable number of drain cycles so late writebacks land before completion.
- It keeps a saturating cycle counter plus NUM_EVENTS saturating event counters, readable through a select mux.
- It replaces the simulation-only cycle counter. It never calls $finish; the bench or SoC reacts to done and timed_out.

Parameters:
- WIDTH, 32, width of the cycle counter and of each event counter.
- DATA_W, 32, width of ret_val and result.
- NUM_EVENTS, 4, number of event strobe inputs and event counters (minimum 1).
- TIMEOUT, 500, cycle budget in RUN. 0 disables the timeout.
- DRAIN, 0, number of cycles spent in DRAIN after halt before DONE.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a run.
- halt  in  1  core halt indication; valid with ret_val.
- ret_val  in  DATA_W  core return value, sampled with halt.
- events  in  NUM_EVENTS  per-cycle event strobes (retire, stall, flush, ...).
- rd_sel  in  $clog2(NUM_EVENTS+1)  0 selects the cycle count; k selects event counter k-1.
- rd_data  out  WIDTH  selected counter value.
- running  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- timed_out  out  1  run ended by timeout.
- result  out  DATA_W  captured ret_val.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE.
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state goes to IDLE.
  - cycle count, all event counters, result, timed_out, done and running go to 0.
- IDLE or DONE, start=1 at an edge:
  - go to RUN.
  - clear all counters, result and timed_out.
  - the first counted cycle is the cycle after that edge.
- RUN or DRAIN: start is ignored.
- IDLE: halt and events are ignored.
- RUN, each edge:
  - cycle count += 1, saturating at 2^WIDTH-1.
  - the edge on which halt is sampled is itself counted.
- Events: counter i += 1 on each edge where state is RUN or DRAIN and events[i]=1, saturating. Counters are frozen in DONE.
- RUN with halt=1:
  - result <= ret_val on the same edge.
  - DRAIN>0: go to DRAIN and load the drain counter with DRAIN-1.
  - DRAIN=0: go directly to DONE.
- DRAIN:
  - the drain counter decrements each edge.
  - at 0, go to DONE. DRAIN therefore lasts exactly DRAIN cycles.
  - halt is ignored.
- Timeout:
  - applies when TIMEOUT!=0, state is RUN and halt=0.
  - the edge that brings the cycle count to TIMEOUT moves the block to DONE with timed_out <= 1 and result unchanged (0).
  - the timeout skips DRAIN.
- Halt and timeout on the same edge: halt wins; normal halt path, timed_out stays 0.
- Outputs:
  - done and timed_out hold in DONE until start or reset.
  - running, done and timed_out are decoded from registered state; no combinational input-to-output path except the rd_sel mux.
  - rd_data is a combinational mux of registered counters.
  - rd_sel > NUM_EVENTS returns 0.
- Latency: with DRAIN=0, done rises on the halt edge. With DRAIN=N, done rises N edges later.

Test Plan:
- Defaults, DRAIN=2: start, halt with ret_val=42 on the 10th RUN edge -> result=42, cycle count (rd_sel=0) = 10, done 2 edges after the halt edge, timed_out=0.
- TIMEOUT=500, halt held 0 -> done and timed_out=1 on the 500th RUN edge, cycle count = 500, result=0; counts frozen after.
- TIMEOUT=500, halt=1 with ret_val=7 on the 500th RUN edge -> timed_out=0, result=7, cycle count = 500.
- DRAIN=2, events[0]=1 constantly, events[1] toggling starting high, halt on the 20th RUN edge:
  - rd_sel=1 reads 22; rd_sel=2 reads 11.
  - events pulsed in IDLE and DONE are not counted.
  - rd_sel=NUM_EVENTS+1 reads 0.
- WIDTH=4, TIMEOUT=0: 20 RUN cycles, then halt -> cycle count saturates at 15, no wrap.
- Start pulse in RUN -> ignored. Assert rst_n=0 mid-DRAIN -> all outputs 0 immediately, before the next clk edge, state IDLE. Restart from DONE -> counters and result cleared.
